// File: rtl/wb_sram_loader_pkg.sv
// ============================================================================
// wb_sram_loader_pkg
//   Register offsets, CTRL/STATUS bit positions and loader FSM states.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package wb_sram_loader_pkg;

   localparam logic [15:0] OFF_CTRL    = 16'h0000;
   localparam logic [15:0] OFF_STATUS  = 16'h0004;
   localparam logic [15:0] OFF_CKSUM   = 16'h0008;
   localparam logic [15:0] OFF_SRAM_LO = 16'h1000;
   localparam logic [15:0] OFF_SRAM_HI = 16'h17FC;

   localparam int CTRL_RUN_BIT = 0;
   localparam int CTRL_CLR_BIT = 2;
   localparam int STAT_RUN_BIT = 0;
   localparam int STAT_ERR_BIT = 1;
   localparam int STAT_CNT_LSB = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_ACK     = 2'd2
   } loader_state_t;

   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{sel[b]}};
      end
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_sram_loader_sram_mux.sv
// ============================================================================
// loader_sram_mux
//   Combinational SRAM port ownership: loader when RUN=0, core when RUN=1.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module loader_sram_mux
   import wb_sram_loader_pkg::*;
#(
   parameter int SRAM_AW = 9
) (
   input  logic               run_i,
   input  logic               ld_en_i,
   input  logic               ld_we_i,
   input  logic [3:0]         ld_wmask_i,
   input  logic [SRAM_AW-1:0] ld_addr_i,
   input  logic [31:0]        ld_wdata_i,
   input  logic               core_en_i,
   input  logic               core_we_i,
   input  logic [3:0]         core_wmask_i,
   input  logic [SRAM_AW-1:0] core_addr_i,
   input  logic [31:0]        core_wdata_i,
   output logic [31:0]        core_rdata_o,
   output logic               sram_en_o,
   output logic               sram_we_o,
   output logic [3:0]         sram_wmask_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [31:0]        sram_wdata_o,
   input  logic [31:0]        sram_rdata_i
);

   always_comb begin
      sram_en_o    = ld_en_i;
      sram_we_o    = ld_we_i;
      sram_wmask_o = ld_wmask_i;
      sram_addr_o  = ld_addr_i;
      sram_wdata_o = ld_wdata_i;
      if (run_i) begin
         sram_en_o    = core_en_i;
         sram_we_o    = core_we_i;
         sram_wmask_o = core_wmask_i;
         sram_addr_o  = core_addr_i;
         sram_wdata_o = core_wdata_i;
      end
   end

   assign core_rdata_o = sram_rdata_i;

endmodule

`default_nettype wire

// File: rtl/wb_sram_loader.sv
// ============================================================================
// wb_sram_loader
//   Wishbone loader for the core SRAM; holds core0 in reset until RUN is set.
//   Optional checksum register: define LOADER_CHECKSUM_EN.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module wb_sram_loader
   import wb_sram_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          SRAM_AW   = 9,
   parameter int          CNT_W     = 10
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   input  logic               core_sram_en_i,
   input  logic               core_sram_we_i,
   input  logic [3:0]         core_sram_wmask_i,
   input  logic [SRAM_AW-1:0] core_sram_addr_i,
   input  logic [31:0]        core_sram_wdata_i,
   output logic [31:0]        core_sram_rdata_o,
   output logic               sram_en_o,
   output logic               sram_we_o,
   output logic [3:0]         sram_wmask_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [31:0]        sram_wdata_o,
   input  logic [31:0]        sram_rdata_i,
   output logic               core_rst_o
);

   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [15:0]      OFF_SRAM_END = OFF_SRAM_HI | 16'h0003;

   loader_state_t    state_q, state_d;
   logic             run_q, run_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      dat_q, dat_d;
   logic             rd_blk_q, rd_blk_d;
   logic             ctrl_wr_q, ctrl_wr_d;
   logic             ctrl_run_q, ctrl_run_d;
   logic             ctrl_clr_q, ctrl_clr_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]      cksum_q, cksum_d;
`endif

   logic [15:0] w_off;
   logic        w_match;
   logic        w_req;
   logic        w_is_sram;
   logic        w_ld_en;
   logic        w_ld_we;

   assign w_off     = wbs_adr_i[15:0];
   assign w_match   = (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
   assign w_req     = wbs_cyc_i & wbs_stb_i & w_match & (state_q == ST_IDLE);
   assign w_is_sram = (w_off >= OFF_SRAM_LO) && (w_off <= OFF_SRAM_END);

   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      dat_d      = dat_q;
      rd_blk_d   = rd_blk_q;
      ctrl_wr_d  = ctrl_wr_q;
      ctrl_run_d = ctrl_run_q;
      ctrl_clr_d = ctrl_clr_q;
`ifdef LOADER_CHECKSUM_EN
      cksum_d    = cksum_q;
`endif
      w_ld_en    = 1'b0;
      w_ld_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_req) begin
               rd_blk_d  = run_q;
               ctrl_wr_d = 1'b0;
               dat_d     = '0;
               state_d   = ST_ACK;
               if (w_is_sram) begin
                  // While the core owns the SRAM, window accesses are flagged and never reach the port.
                  if (run_q) begin
                     err_d = 1'b1;
                  end
                  if (wbs_we_i) begin
                     if (!run_q) begin
                        w_ld_en = 1'b1;
                        w_ld_we = 1'b1;
                        if (cnt_q != CNT_MAX) begin
                           cnt_d = cnt_q + 1'b1;
                        end
`ifdef LOADER_CHECKSUM_EN
                        cksum_d = cksum_q + (wbs_dat_i & byte_mask(wbs_sel_i));
`endif
                     end
                  end else begin
                     w_ld_en = !run_q;
                     state_d = ST_RD_WAIT;
                  end
               end else if (wbs_we_i) begin
                  if (w_off == OFF_CTRL) begin
                     ctrl_wr_d  = 1'b1;
                     ctrl_run_d = wbs_dat_i[CTRL_RUN_BIT];
                     ctrl_clr_d = wbs_dat_i[CTRL_CLR_BIT];
                  end
               end else begin
                  case (w_off)
                     OFF_CTRL: dat_d[CTRL_RUN_BIT] = run_q;
                     OFF_STATUS: begin
                        dat_d[STAT_RUN_BIT]              = run_q;
                        dat_d[STAT_ERR_BIT]              = err_q;
                        dat_d[STAT_CNT_LSB +: CNT_W]     = cnt_q;
                     end
`ifdef LOADER_CHECKSUM_EN
                     OFF_CKSUM: dat_d = cksum_q;
`endif
                     default: dat_d = '0;
                  endcase
               end
            end
         end
         ST_RD_WAIT: begin
            dat_d   = rd_blk_q ? 32'h0 : sram_rdata_i;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            // CTRL takes effect as the ack retires, so core_rst_o moves the cycle after the ack.
            state_d   = ST_IDLE;
            ctrl_wr_d = 1'b0;
            if (ctrl_wr_q) begin
               run_d = ctrl_run_q;
               if (ctrl_clr_q) begin
                  cnt_d = '0;
                  err_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  cksum_d = '0;
`endif
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         dat_q      <= '0;
         rd_blk_q   <= 1'b0;
         ctrl_wr_q  <= 1'b0;
         ctrl_run_q <= 1'b0;
         ctrl_clr_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         cksum_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         dat_q      <= dat_d;
         rd_blk_q   <= rd_blk_d;
         ctrl_wr_q  <= ctrl_wr_d;
         ctrl_run_q <= ctrl_run_d;
         ctrl_clr_q <= ctrl_clr_d;
`ifdef LOADER_CHECKSUM_EN
         cksum_q    <= cksum_d;
`endif
      end
   end

   assign wbs_ack_o  = (state_q == ST_ACK);
   assign wbs_dat_o  = dat_q;
   assign core_rst_o = ~run_q;

   loader_sram_mux #(
      .SRAM_AW (SRAM_AW)
   ) u_mux (
      .run_i        (run_q & ~wb_rst_i),
      .ld_en_i      (w_ld_en & ~wb_rst_i),
      .ld_we_i      (w_ld_we & ~wb_rst_i),
      .ld_wmask_i   (wbs_sel_i),
      .ld_addr_i    (wbs_adr_i[2 +: SRAM_AW]),
      .ld_wdata_i   (wbs_dat_i),
      .core_en_i    (core_sram_en_i),
      .core_we_i    (core_sram_we_i),
      .core_wmask_i (core_sram_wmask_i),
      .core_addr_i  (core_sram_addr_i),
      .core_wdata_i (core_sram_wdata_i),
      .core_rdata_o (core_sram_rdata_o),
      .sram_en_o    (sram_en_o),
      .sram_we_o    (sram_we_o),
      .sram_wmask_o (sram_wmask_o),
      .sram_addr_o  (sram_addr_o),
      .sram_wdata_o (sram_wdata_o),
      .sram_rdata_i (sram_rdata_i)
   );

endmodule

`default_nettype wire

// File: tb/tb_wb_sram_loader.sv
// ============================================================================
// tb_wb_sram_loader
//   Randomized scoreboard bench for wb_sram_loader with a behavioural model.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_sram_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0, wdat = '0;
   logic        ack;
   logic [31:0] rdat;
   logic        c_en = 1'b0, c_we = 1'b0;
   logic [3:0]  c_wmask = 4'h0;
   logic [8:0]  c_addr = '0;
   logic [31:0] c_wdata = '0;
   logic [31:0] c_rdata;
   logic        s_en, s_we;
   logic [3:0]  s_wmask;
   logic [8:0]  s_addr;
   logic [31:0] s_wdata;
   logic [31:0] s_rdata = '0;
   logic        core_rst;

   always #5 clk = ~clk;

   wb_sram_loader dut (
      .wb_clk_i          (clk),
      .wb_rst_i          (rst),
      .wbs_cyc_i         (cyc),
      .wbs_stb_i         (stb),
      .wbs_we_i          (we),
      .wbs_sel_i         (sel),
      .wbs_adr_i         (adr),
      .wbs_dat_i         (wdat),
      .wbs_ack_o         (ack),
      .wbs_dat_o         (rdat),
      .core_sram_en_i    (c_en),
      .core_sram_we_i    (c_we),
      .core_sram_wmask_i (c_wmask),
      .core_sram_addr_i  (c_addr),
      .core_sram_wdata_i (c_wdata),
      .core_sram_rdata_o (c_rdata),
      .sram_en_o         (s_en),
      .sram_we_o         (s_we),
      .sram_wmask_o      (s_wmask),
      .sram_addr_o       (s_addr),
      .sram_wdata_o      (s_wdata),
      .sram_rdata_i      (s_rdata),
      .core_rst_o        (core_rst)
   );

   // Physical SRAM stand-in: read data appears one cycle after en.
   logic [31:0] sram_mem [512];
   always @(posedge clk) begin
      if (s_en) begin
         if (s_we) begin
            for (int b = 0; b < 4; b++)
               if (s_wmask[b]) sram_mem[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
         end else begin
            s_rdata <= sram_mem[s_addr];
         end
      end
   end

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model state
   logic [31:0] m_mem [512];
   bit          m_run, m_err;
   int          m_cnt;
   logic [31:0] m_ck;

   typedef struct {
      string       name;
      bit          chk_data;
      logic [31:0] exp;
      int          start;
      int          lat;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (ack) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got ack expected none");
         end else begin
            mon_e = sbq.pop_front();
            check({mon_e.name, "_lat"}, 32'(cyc_cnt - mon_e.start), 32'(mon_e.lat));
            if (mon_e.chk_data) check(mon_e.name, rdat, mon_e.exp);
         end
      end
   end

   task automatic model_reset();
      m_run = 0; m_err = 0; m_cnt = 0; m_ck = '0;
   endtask

   // Issue one matched bus access; the model predicts the response first.
   task automatic bus(input string nm, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, output logic rst_at_ack);
      exp_t        e;
      logic [15:0] off;
      int          idx;
      bit          got;
      logic [31:0] bm;
      off = a[15:0];
      idx = int'(a[10:2]);
      e.name = nm; e.chk_data = !w; e.exp = '0; e.lat = 1;
      bm = '0;
      for (int b = 0; b < 4; b++) if (s[b]) bm[8*b +: 8] = 8'hFF;
      if (off >= 16'h1000 && off <= 16'h17FF) begin
         if (m_run) m_err = 1;
         if (w) begin
            if (!m_run) begin
               m_mem[idx] = (m_mem[idx] & ~bm) | (d & bm);
               if (m_cnt < 1023) m_cnt++;
               m_ck = m_ck + (d & bm);
            end
         end else begin
            e.lat = 2;
            e.exp = m_run ? 32'h0 : m_mem[idx];
         end
      end else if (off == 16'h0000) begin
         if (w) begin
            if (d[2]) begin m_cnt = 0; m_err = 0; m_ck = '0; end
            m_run = d[0];
         end else e.exp = {31'h0, m_run};
      end else if (off == 16'h0004) begin
         e.exp = (32'(m_cnt) << 16) | (32'(m_err) << 1) | 32'(m_run);
      end else if (off == 16'h0008) begin
`ifdef LOADER_CHECKSUM_EN
         e.exp = m_ck;
`else
         e.exp = 32'h0;
`endif
      end
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
      e.start = cyc_cnt;
      sbq.push_back(e);
      got = 0;
      rst_at_ack = 1'bx;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack) begin got = 1; rst_at_ack = core_rst; break; end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL %s_timeout: got no ack expected ack", nm);
         void'(sbq.pop_back());
      end
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic probe_mismatch(input logic [31:0] a);
      int acks;
      acks = 0;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = $urandom_range(0, 1); adr = a; sel = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack) acks++;
      end
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0;
      check("mismatch_no_ack", 32'(acks), 32'd0);
   endtask

   localparam logic [31:0] B = 32'h3000_0000;

   initial begin
      logic ra;
      logic [31:0] a, d;
      int kind, acks, diffs;
      foreach (sram_mem[i]) sram_mem[i] = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
      model_reset();

      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_core_rst", 32'(core_rst), 32'd1);
      check("reset_sram_en", 32'(s_en), 32'd0);
      check("reset_ack", 32'(ack), 32'd0);
      rst = 0;

      bus("status_after_reset", 0, B + 32'h4, 0, 4'hF, ra);
      bus("wr_1000", 1, B + 32'h1000, 32'h0030_0193, 4'hF, ra);
      bus("wr_1004", 1, B + 32'h1004, 32'h0030_0213, 4'hF, ra);
      bus("rd_1000", 0, B + 32'h1000, 0, 4'hF, ra);
      bus("rd_1004", 0, B + 32'h1004, 0, 4'hF, ra);
      bus("status_cnt2", 0, B + 32'h4, 0, 4'hF, ra);

      bus("ctrl_run", 1, B, 32'h1, 4'hF, ra);
      check("core_rst_during_ack", 32'(ra), 32'd1);
      check("core_rst_after_run", 32'(core_rst), 32'd0);

      c_en = 1; c_we = 0; c_addr = 9'd1;
      #1;
      check("core_pass_en", 32'(s_en), 32'd1);
      check("core_pass_addr", 32'(s_addr), 32'd1);
      @(posedge clk); #1;
      c_en = 0;
      check("core_rdata", c_rdata, 32'h0030_0213);

      bus("wr_locked", 1, B + 32'h1008, 32'hDEAD_BEEF, 4'hF, ra);
      bus("status_err", 0, B + 32'h4, 0, 4'hF, ra);
      bus("rd_locked", 0, B + 32'h1000, 0, 4'hF, ra);
      check("locked_sram_untouched", sram_mem[2], 32'h0);

      bus("ctrl_clr_stop", 1, B, 32'h4, 4'hF, ra);
      check("core_rst_after_stop", 32'(core_rst), 32'd1);
      bus("ck_wr0", 1, B + 32'h1000, 32'h0000_00FF, 4'b0001, ra);
      bus("ck_wr1", 1, B + 32'h1004, 32'h0000_0100, 4'hF, ra);
      bus("cksum_rd", 0, B + 32'h8, 0, 4'hF, ra);
`ifdef LOADER_CHECKSUM_EN
      check("cksum_model", m_ck, 32'h0000_01FF);
`endif
      bus("ctrl_clr", 1, B, 32'h4, 4'hF, ra);
      bus("cksum_after_clr", 0, B + 32'h8, 0, 4'hF, ra);
      bus("status_after_clr", 0, B + 32'h4, 0, 4'hF, ra);

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 99);
         d = $urandom;
         if (kind < 45) begin
            a = B + 32'h1000 + 32'($urandom_range(0, 15) * 4);
            bus("rnd_wr", 1, a, d, 4'($urandom), ra);
         end else if (kind < 70) begin
            a = B + 32'h1000 + 32'($urandom_range(0, 15) * 4);
            bus("rnd_rd", 0, a, 0, 4'hF, ra);
         end else if (kind < 82) begin
            a = B + 32'($urandom_range(0, 2) * 4);
            bus("rnd_reg_rd", 0, a, 0, 4'hF, ra);
         end else if (kind < 88) begin
            d = {29'h0, ($urandom_range(0, 3) == 0), 1'b0, ($urandom_range(0, 3) == 0)};
            bus("rnd_ctrl_wr", 1, B, d, 4'hF, ra);
         end else if (kind < 95) begin
            a = B + (($urandom_range(0, 1) == 1) ? 32'h2000 : 32'h000C);
            bus("rnd_unmapped", $urandom_range(0, 1), a, d, 4'hF, ra);
         end else begin
            probe_mismatch(32'h3001_1000);
         end
      end

      bus("sat_clr", 1, B, 32'h4, 4'hF, ra);
      for (int n = 0; n < 1030; n++)
         bus("sat_wr", 1, B + 32'h1000 + 32'($urandom_range(0, 31) * 4), $urandom, 4'hF, ra);
      bus("status_sat", 0, B + 32'h4, 0, 4'hF, ra);

      bus("ctrl_run2", 1, B, 32'h1, 4'hF, ra);
      acks = 0;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; adr = B + 32'h1000; sel = 4'hF;
      @(negedge clk); if (ack) acks++;
      @(posedge clk); #1;
      rst = 1; cyc = 0; stb = 0;
      @(negedge clk); if (ack) acks++;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); if (ack) acks++;
      end
      check("rst_in_rdwait_no_ack", 32'(acks), 32'd0);
      check("rst_in_rdwait_core_rst", 32'(core_rst), 32'd1);
      bus("status_after_midrst", 0, B + 32'h4, 0, 4'hF, ra);

      @(posedge clk); #1;
      rst = 1; cyc = 1; stb = 1; we = 1; adr = B + 32'h1000; wdat = 32'h1234_5678; sel = 4'hF;
      #1;
      check("rst_write_suppressed", 32'(s_en), 32'd0);
      @(posedge clk); #1;
      rst = 0; cyc = 0; stb = 0; we = 0;

      repeat (4) @(posedge clk);
      #1;
      diffs = 0;
      for (int i = 0; i < 512; i++) if (sram_mem[i] !== m_mem[i]) diffs++;
      check("sram_image", 32'(diffs), 32'd0);
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/wb_sram_loader.md
Name: wb_sram_loader

Overview:
- Wishbone slave between the Caravel management SoC and the user-project `custom_sram` (512 x 32-bit).
- Firmware loads the core's program image into SRAM through the Wishbone bus, holding `core0` in reset meanwhile.
- A CTRL write then hands the SRAM port to the core and releases it.
- Sits directly upstream of `core0`/`custom_sram`: it produces the memory image and reset release the core consumes.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base; match on `wbs_adr_i[31:16] == BASE_ADDR[31:16]`.
- SRAM_AW, 9, SRAM word-address width (512 words).
- CNT_W, 10, width of the load word counter.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- core_sram_en_i / core_sram_we_i  in  1/1  core memory request
- core_sram_wmask_i  in  4  core byte mask
- core_sram_addr_i  in  SRAM_AW  core word address
- core_sram_wdata_i  in  32  core write data
- core_sram_rdata_o  out  32  SRAM read data returned to core
- sram_en_o / sram_we_o  out  1/1  SRAM port controls
- sram_wmask_o  out  4  SRAM byte mask
- sram_addr_o  out  SRAM_AW  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, valid 1 cycle after en
- core_rst_o  out  1  active-high reset to core0

Behaviour:
- Reset, synchronous on `wb_rst_i`:
  - RUN=0, ERR=0, count=0.
  - `core_rst_o`=1, `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `sram_en_o`=0, `sram_we_o`=0.
  - FSM=IDLE.
- Register map (offset = `adr[15:0]`):
  - 0x0000 CTRL: bit0 RUN (R/W); bit2 CLR (write-1, self-clearing, zeroes count/ERR/checksum).
  - 0x0004 STATUS (RO): bit0 RUN, bit1 ERR sticky, [25:16] count.
  - 0x0008 CHECKSUM (RO, optional feature).
  - 0x1000–0x17FC: SRAM window, word index = `adr[10:2]`.
- Unmapped offsets and address mismatch:
  - Mismatch: no ack.
  - Matched but unmapped offset: ack in 1 cycle, read 0, write ignored.
- FSM states: IDLE, RD_WAIT, ACK.
  - IDLE: `cyc&stb&match` and no ack pending → register access or SRAM write → ACK.
  - IDLE: SRAM read → drive sram_en (we=0) → RD_WAIT.
  - RD_WAIT: latch `sram_rdata_i` → ACK.
  - ACK: `wbs_ack_o`=1 for exactly one cycle → IDLE.
- Latency:
  - Register read/write and SRAM write: ack 1 cycle after request.
  - SRAM read: ack 2 cycles after request.
- SRAM write from the bus:
  - Issued in the IDLE cycle, with `wmask = wbs_sel_i`.
  - When RUN=0: count +1, saturating at 1023.
- Ownership:
  - RUN=0: loader drives the SRAM port; core inputs ignored; `core_sram_rdata_o` = `sram_rdata_i` (don't-care).
  - RUN=1: SRAM port is a combinational pass-through of the core_* signals.
- SRAM window access while RUN=1:
  - Acked normally, write dropped, read returns 0, ERR set.
  - The SRAM port is never driven by the bus.
- RUN transitions:
  - RUN 0→1: `core_rst_o` falls in the cycle after the CTRL ack.
  - RUN 1→0: `core_rst_o` rises in the cycle after the ack; a core access in that cycle is dropped.
  - Writing RUN with its current value is a no-op.
  - CLR and RUN written together: both take effect.
- Reset asserted mid-transaction: FSM returns to IDLE, no ack issued, the SRAM write from that cycle is suppressed.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - 32-bit checksum register, mod 2^32.
  - On each accepted bus SRAM write with RUN=0, adds `wbs_dat_i` masked by the byte-expanded `wbs_sel_i`.
  - Readable at 0x0008; cleared by reset and by CLR.
- Undefined: no checksum register is built; 0x0008 reads 0.

Decomposition:
- Package `wb_sram_loader_pkg`:
  - Offsets OFF_CTRL / OFF_STATUS / OFF_CKSUM / OFF_SRAM_LO / OFF_SRAM_HI.
  - CTRL/STATUS bit positions.
  - FSM state enum `loader_state_t` (IDLE, RD_WAIT, ACK).
- Sub-module `loader_sram_mux`: purely combinational selection of the SRAM port between loader and core, keyed on RUN.

Test Plan:
- Reset, then read STATUS → 0x0000_0000; `core_rst_o`=1, `sram_en_o`=0.
- Write 0x1000=0x0030_0193 and 0x1004=0x0030_0213, then read them back:
  - ack at +1 cycle for writes, +2 cycles for reads;
  - data matches;
  - STATUS[25:16]=2.
- Write CTRL=1:
  - `core_rst_o` falls the cycle after the ack;
  - core request addr=1, en=1 → `sram_addr_o`=1, `core_sram_rdata_o`=0x0030_0213 next cycle.
- With RUN=1, write 0x1008=0xDEAD_BEEF → ack, SRAM unchanged, STATUS bit1=1; read 0x1000 → 0.
- With LOADER_CHECKSUM_EN defined:
  - Write 0x1000=0x0000_00FF with sel=4'b0001, then 0x1004=0x0000_0100 with sel=4'hF → CHECKSUM=0x0000_01FF.
  - CTRL=4 (CLR) → CHECKSUM=0, count=0.
- Assert `wb_rst_i` in the RD_WAIT cycle → no ack, `core_rst_o`=1, RUN=0 afterwards.
